// File: rtl/pool_post_mac_fixed_if.sv
// Lane-parallel pooled-result stream with byte keep and row-last marker.
// The source drives the beat and valid, the sink drives ready.
interface pool_post_mac_fixed_if #(
  parameter int LANE_N = 4
);
  logic [16*LANE_N-1:0] data;
  logic [2*LANE_N-1:0]  keep;
  logic                 last;
  logic                 valid;
  logic                 ready;

  modport master (
    output data, keep, last, valid,
    input  ready
  );

  modport slave (
    input  data, keep, last, valid,
    output ready
  );
endinterface

// File: rtl/pool_post_mac_fixed.sv
// Post-MAC fixed-point stage: y = sat(((x*A) >>> Q) + B) per lane.
// Three stages: multiply, round/shift/add, saturate/register.
module pool_post_mac_fixed #(
  parameter int LANE_N    = 4,
  parameter int SAT_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_post_mac,
  input  logic [1:0]           calfmt,
  input  logic [4:0]           post_mac_fixed_point_quat_accrc,
  input  logic                 post_mac_is_a_eq_1,
  input  logic                 post_mac_is_b_eq_0,
  input  logic [31:0]          post_mac_param_a,
  input  logic [31:0]          post_mac_param_b,
  pool_post_mac_fixed_if.slave  s_axis,
  pool_post_mac_fixed_if.master m_axis,
  input  logic                 sat_cnt_clr,
  output logic [SAT_CNT_W-1:0] sat_cnt
);
  localparam int DW = 16 * LANE_N;
  localparam int KW = 2 * LANE_N;
  localparam int CW = $clog2(LANE_N + 1);

  function automatic logic [31:0] mul(
    input logic [15:0] d,
    input logic        i8,
    input logic        a1,
    input logic [15:0] a
  );
    logic [31:0] x;
    x = i8 ? {{24{d[7]}}, d[7:0]} : {{16{d[15]}}, d};
    if (a1) return x;
    return $signed(x) * $signed({{16{a[15]}}, a});
  endfunction

  function automatic logic [47:0] scale(
    input logic [31:0] p,
    input logic [4:0]  q,
    input logic        a1,
    input logic        b0,
    input logic [31:0] b
  );
    logic signed [47:0] v;
    v = {{16{p[31]}}, p};
    if (!a1 && q != 5'd0)
      v = (v + (48'sd1 <<< (q - 5'd1))) >>> q;
    if (!b0)
      v = v + $signed({{16{b[31]}}, b});
    return v;
  endfunction

  function automatic logic [16:0] clip(
    input logic [47:0] s,
    input logic        i8
  );
    logic signed [47:0] v;
    logic signed [47:0] hi;
    logic signed [47:0] lo;
    v  = s;
    hi = i8 ? 48'sd127 : 48'sd32767;
    lo = i8 ? -48'sd128 : -48'sd32768;
    if (v > hi) return {1'b1, hi[15:0]};
    if (v < lo) return {1'b1, lo[15:0]};
    return {1'b0, v[15:0]};
  endfunction

  logic ce;
  logic fire;
  logic in_i8;
  logic in_byp;
  logic unused_a;

  assign ce           = m_axis.ready | ~m_axis.valid;
  assign fire         = m_axis.valid & m_axis.ready;
  assign s_axis.ready = ce;
  assign in_i8        = calfmt == 2'b00;
  assign in_byp       = ~en_post_mac | calfmt[1];
  assign unused_a     = ^post_mac_param_a[31:16];

  logic                    s1_vld;
  logic                    s1_last;
  logic                    s1_byp;
  logic                    s1_i8;
  logic                    s1_a1;
  logic                    s1_b0;
  logic [4:0]              s1_q;
  logic [31:0]             s1_b;
  logic [KW-1:0]           s1_keep;
  logic [DW-1:0]           s1_raw;
  logic [LANE_N-1:0][31:0] s1_p;
  logic [LANE_N-1:0][31:0] p_c;

  // Lane sign-extension and A multiply for the incoming beat.
  always_comb begin
    p_c = '0;
    for (int i = 0; i < LANE_N; i++)
      p_c[i] = mul(s_axis.data[16*i +: 16], in_i8,
                   post_mac_is_a_eq_1, post_mac_param_a[15:0]);
  end

  // S1: capture beat, its config snapshot and lane products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
      s1_byp  <= 1'b0;
      s1_i8   <= 1'b0;
      s1_a1   <= 1'b0;
      s1_b0   <= 1'b0;
      s1_q    <= '0;
      s1_b    <= '0;
      s1_keep <= '0;
      s1_raw  <= '0;
      s1_p    <= '0;
    end else if (ce) begin
      s1_vld  <= s_axis.valid;
      s1_last <= s_axis.last;
      s1_byp  <= in_byp;
      s1_i8   <= in_i8;
      s1_a1   <= post_mac_is_a_eq_1;
      s1_b0   <= post_mac_is_b_eq_0;
      s1_q    <= post_mac_fixed_point_quat_accrc;
      s1_b    <= post_mac_param_b;
      s1_keep <= s_axis.keep;
      s1_raw  <= s_axis.data;
      s1_p    <= p_c;
    end
  end

  logic                    s2_vld;
  logic                    s2_last;
  logic                    s2_byp;
  logic                    s2_i8;
  logic [KW-1:0]           s2_keep;
  logic [DW-1:0]           s2_raw;
  logic [LANE_N-1:0][47:0] s2_s;
  logic [LANE_N-1:0][47:0] s_c;

  // Round-half-up shift by Q, then add B, in 48 bits.
  always_comb begin
    s_c = '0;
    for (int i = 0; i < LANE_N; i++)
      s_c[i] = scale(s1_p[i], s1_q, s1_a1, s1_b0, s1_b);
  end

  // S2: register scaled sums alongside raw data for bypass lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld  <= 1'b0;
      s2_last <= 1'b0;
      s2_byp  <= 1'b0;
      s2_i8   <= 1'b0;
      s2_keep <= '0;
      s2_raw  <= '0;
      s2_s    <= '0;
    end else if (ce) begin
      s2_vld  <= s1_vld;
      s2_last <= s1_last;
      s2_byp  <= s1_byp;
      s2_i8   <= s1_i8;
      s2_keep <= s1_keep;
      s2_raw  <= s1_raw;
      s2_s    <= s_c;
    end
  end

  logic [LANE_N-1:0][16:0] c_c;
  logic [DW-1:0]           y_c;
  logic [CW-1:0]           n_c;
  logic [CW-1:0]           s3_n;

  // Clip kept lanes in active mode; others pass raw.
  always_comb begin
    c_c = '0;
    y_c = s2_raw;
    n_c = '0;
    for (int i = 0; i < LANE_N; i++) begin
      c_c[i] = clip(s2_s[i], s2_i8);
      if (!s2_byp && s2_keep[2*i]) begin
        y_c[16*i +: 16] = c_c[i][15:0];
        n_c = n_c + CW'(c_c[i][16]);
      end
    end
  end

  // S3: output register, held while the writer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis.valid <= 1'b0;
      m_axis.data  <= '0;
      m_axis.keep  <= '0;
      m_axis.last  <= 1'b0;
      s3_n         <= '0;
    end else if (ce) begin
      m_axis.valid <= s2_vld;
      m_axis.data  <= y_c;
      m_axis.keep  <= s2_keep;
      m_axis.last  <= s2_last;
      s3_n         <= n_c;
    end
  end

  logic [SAT_CNT_W:0] sum;

  assign sum = {1'b0, sat_cnt} + (SAT_CNT_W+1)'(s3_n);

  // Sticky saturation counter; clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sat_cnt <= '0;
    else if (sat_cnt_clr)
      sat_cnt <= '0;
    else if (fire)
      sat_cnt <= sum[SAT_CNT_W] ? '1 : sum[SAT_CNT_W-1:0];
  end
endmodule
